vending_sequencer: RTL and testbench
====================================

# vending_sequencer

Sequencer for the vending-machine coin path. It latches a product selection, accumulates inserted coins into a 4-bit credit register, and drives the coin comparator's `Reg`/`sel` inputs. It reads back the comparator's `equal` (credit ≥ price) flag, then runs the dispense and change-return phases. It sits between the front-panel/coin-acceptor inputs and the comparator, dispenser and change-hopper outputs.

## Interface
Parameters:
- `PRICE1`, default 1: price of product sel=1.
- `PRICE2`, default 4: price of product sel=2.
- `PRICE3`, default 5: price of product sel=3.
- `PRICE4`, default 7: price of product sel=4.
- `DISPENSE_CYCLES`, default 4: cycles `dispense` is held high (≥1).

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sel_in` in 3: product code; valid codes 1..4.
- `sel_valid` in 1: one-cycle strobe qualifying `sel_in`.
- `coin1` in 1: one-cycle pulse, coin of value 1.
- `coin2` in 1: one-cycle pulse, coin of value 2.
- `cancel` in 1: refund request; used only with `VEND_CANCEL_EN`.
- `cmp_ge` in 1: comparator `equal` output.
- `cmp_reg` out 4: registered credit, drives comparator `Reg`.
- `cmp_sel` out 3: registered selection, drives comparator `sel`.
- `dispense` out 1: dispenser drive.
- `change_pulse` out 1: one pulse per returned unit.
- `coin_reject` out 1: one-cycle pulse when a coin is refused.
- `sel_err` out 1: one-cycle pulse on an invalid or ignored selection.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, COLLECT, DISPENSE, CHANGE.

IDLE:
- `cmp_sel`=0, credit=0.
- `sel_valid` with `sel_in` in 1..4: latch `cmp_sel`=`sel_in`, go to COLLECT.
- `sel_valid` with `sel_in` of 0 or 5..7: `sel_err` pulse, stay in IDLE.
- Any coin: `coin_reject` pulse, credit unchanged.

COLLECT:
- Credit add per cycle is `coin1`×1 + `coin2`×2; simultaneous coins add 3.
- If credit + add > 15: the whole add is refused, credit unchanged, `coin_reject` pulse.
- If `cmp_ge`=1: go to DISPENSE. Coins arriving in that same cycle are still added.
- `sel_valid`: ignored, `sel_err` pulse; the selection is not changed.

DISPENSE:
- On entry, credit ← credit − PRICE[`cmp_sel`]. Arithmetic is 4-bit unsigned; no underflow is possible because `cmp_ge` was 1.
- `dispense`=1 for exactly DISPENSE_CYCLES cycles.
- Then go to CHANGE if credit>0, else to IDLE.

CHANGE:
- Each cycle: `change_pulse`=1 and credit decrements by 1.
- When credit reaches 0, go to IDLE and clear `cmp_sel` to 0.

In DISPENSE and CHANGE:
- Every coin: `coin_reject` pulse.
- Every `sel_valid`: `sel_err` pulse.

Other rules:
- `busy` is a decode of the state register.
- Reset at any point (including mid-DISPENSE or mid-CHANGE) returns to IDLE immediately; pending change is discarded.
- Reset values: state=IDLE, `cmp_reg`=0, `cmp_sel`=0, `dispense`=0, `change_pulse`=0, `coin_reject`=0, `sel_err`=0, `busy`=0.

## Timing
- All outputs are registered.
- Selection strobe in cycle N: `cmp_sel` and `busy` valid in N+1.
- Coin pulse in cycle N: `cmp_reg` updated in N+1; `coin_reject` asserted in N+1.
- `cmp_ge` is combinational from `cmp_reg`/`cmp_sel` and is sampled in the cycle it is valid. Credit reaching the price in N+1 gives `dispense`=1 from N+2 through N+1+DISPENSE_CYCLES.
- First `change_pulse` is in the cycle after the last `dispense` cycle. Pulses are back-to-back: change of k units takes exactly k cycles.
- After the last pulse, or after dispense when no change is due, the next cycle is IDLE.
- A selection can be accepted in that first IDLE cycle.

## Configuration
- `VEND_CANCEL_EN` defined:
  - In COLLECT, `cancel`=1 moves to CHANGE next cycle.
  - If credit>0, the full credit is refunded.
  - If credit=0, go straight to IDLE.
  - No dispense occurs; `cmp_sel` is cleared on return to IDLE.
  - Cancel has priority over `cmp_ge` in the same cycle. Coins in the cancel cycle are rejected.
- `VEND_CANCEL_EN` undefined:
  - `cancel` is ignored in all states; the port is kept.
  - A selection can only be exited by buying or by reset.

## Test plan
- Reset then sel=2 with coins 2,2: `cmp_reg` goes 0→2→4; `dispense` high 4 cycles; zero `change_pulse`; `busy` low after.
- sel=4 with coins 2,2,2,2: credit 8 ≥ 7, dispense, then exactly 1 `change_pulse`; final `cmp_reg`=0.
- sel=1 with `coin1` and `coin2` in the same cycle: credit 3, dispense, 2 change pulses on consecutive cycles.
- `sel_in`=6 in IDLE: `sel_err` pulse, `busy` stays 0. Coin while idle: `coin_reject`, credit 0. Coin during DISPENSE: `coin_reject`, credit unchanged.
- Credit saturation: sel=4 with `PRICE4` overridden to 15, coins up to 14 then `coin2`: rejected, credit stays 14. Then `coin1`: credit 15, dispense.
- With `VEND_CANCEL_EN`: sel=3, coins 2,2, then `cancel` → 4 change pulses, no `dispense`, IDLE. Without the macro: same stimulus, credit stays 4 and the block stays in COLLECT. `rst` mid-CHANGE: IDLE next cycle with all outputs 0.

Source files
------------

// File: rtl/vending_sequencer.sv
// Coin-path sequencer for the vending machine: latches a selection, accumulates credit,
// dispenses, then returns change. Optional cancel/refund path enabled by VEND_CANCEL_EN.
module vending_sequencer #(
    parameter int PRICE1          = 1,
    parameter int PRICE2          = 4,
    parameter int PRICE3          = 5,
    parameter int PRICE4          = 7,
    parameter int DISPENSE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sel_in,
    input  logic       sel_valid,
    input  logic       coin1,
    input  logic       coin2,
    input  logic       cancel,
    input  logic       cmp_ge,
    output logic [3:0] cmp_reg,
    output logic [2:0] cmp_sel,
    output logic       dispense,
    output logic       change_pulse,
    output logic       coin_reject,
    output logic       sel_err,
    output logic       busy
);

    localparam int CW = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DISPENSE,
        S_CHANGE
    } state_t;

    state_t          r_state;
    logic [3:0]      r_credit;
    logic [2:0]      r_sel;
    logic [CW-1:0]   r_cnt;
    logic            r_disp;
    logic            r_chg;
    logic            r_rej;
    logic            r_err;

    logic            w_coin_any;
    logic [4:0]      w_add;
    logic [4:0]      w_sum;
    logic            w_fits;
    logic            w_sel_ok;
    logic [3:0]      w_price;
    logic [3:0]      w_credit_buy;
    logic            w_cancel;

`ifdef VEND_CANCEL_EN
    assign w_cancel = cancel;
`else
    logic w_unused_cancel;
    assign w_unused_cancel = cancel;
    assign w_cancel        = 1'b0;
`endif

    assign w_coin_any = coin1 | coin2;
    assign w_add      = {4'd0, coin1} + {3'd0, coin2, 1'b0};
    assign w_sum      = {1'b0, r_credit} + w_add;
    assign w_fits     = ~w_sum[4];
    assign w_sel_ok   = (sel_in != 3'd0) && (sel_in <= 3'd4);

    always_comb begin
        w_price = 4'd0;
        case (r_sel)
            3'd1:    w_price = 4'(PRICE1);
            3'd2:    w_price = 4'(PRICE2);
            3'd3:    w_price = 4'(PRICE3);
            3'd4:    w_price = 4'(PRICE4);
            default: w_price = 4'd0;
        endcase
    end

    // Coins arriving in the purchase cycle are credited before the price is taken off.
    assign w_credit_buy = (w_fits ? w_sum[3:0] : r_credit) - w_price;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_credit <= 4'd0;
            r_sel    <= 3'd0;
            r_cnt    <= '0;
            r_disp   <= 1'b0;
            r_chg    <= 1'b0;
            r_rej    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rej <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_credit <= 4'd0;
                    r_rej    <= w_coin_any;
                    if (sel_valid) begin
                        if (w_sel_ok) begin
                            r_sel   <= sel_in;
                            r_state <= S_COLLECT;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    r_err <= sel_valid;
                    if (w_cancel) begin
                        r_rej <= w_coin_any;
                        if (r_credit != 4'd0) begin
                            r_state <= S_CHANGE;
                            r_chg   <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_sel   <= 3'd0;
                        end
                    end else begin
                        r_rej <= w_coin_any & ~w_fits;
                        if (cmp_ge) begin
                            r_state  <= S_DISPENSE;
                            r_credit <= w_credit_buy;
                            r_disp   <= 1'b1;
                            r_cnt    <= CW'(DISPENSE_CYCLES - 1);
                        end else if (w_fits) begin
                            r_credit <= w_sum[3:0];
                        end
                    end
                end
                S_DISPENSE: begin
                    r_rej <= w_coin_any;
                    r_err <= sel_valid;
                    if (r_cnt == '0) begin
                        r_disp <= 1'b0;
                        if (r_credit != 4'd0) begin
                            r_state <= S_CHANGE;
                            r_chg   <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_sel   <= 3'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_CHANGE: begin
                    r_rej <= w_coin_any;
                    r_err <= sel_valid;
                    if (r_credit <= 4'd1) begin
                        r_credit <= 4'd0;
                        r_chg    <= 1'b0;
                        r_sel    <= 3'd0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_credit <= r_credit - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmp_reg      = r_credit;
    assign cmp_sel      = r_sel;
    assign dispense     = r_disp;
    assign change_pulse = r_chg;
    assign coin_reject  = r_rej;
    assign sel_err      = r_err;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_vending_sequencer.sv
// Directed bench for vending_sequencer: cycle vectors on a default-price instance plus a
// saturation sequence on an instance with PRICE4=15. Honours VEND_CANCEL_EN.
module tb_vending_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       sv;
        logic [2:0] sel;
        logic       c1;
        logic       c2;
        logic       cn;
        logic [3:0] exp_reg;
        logic [2:0] exp_sel;
        logic [4:0] exp_flags; // {dispense, change_pulse, coin_reject, sel_err, busy}
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [3:0] price_of(input logic [2:0] s, input logic [3:0] p4);
        case (s)
            3'd1:    return 4'd1;
            3'd2:    return 4'd4;
            3'd3:    return 4'd5;
            3'd4:    return p4;
            default: return 4'd15;
        endcase
    endfunction

    // Instance A: default parameters
    logic       a_rst, a_sv, a_c1, a_c2, a_cn, a_ge;
    logic [2:0] a_sel_in, a_sel;
    logic [3:0] a_reg;
    logic       a_disp, a_chg, a_rej, a_err, a_busy;

    assign a_ge = (a_reg >= price_of(a_sel, 4'd7));

    vending_sequencer dut_a (
        .clk(clk), .rst(a_rst), .sel_in(a_sel_in), .sel_valid(a_sv),
        .coin1(a_c1), .coin2(a_c2), .cancel(a_cn), .cmp_ge(a_ge),
        .cmp_reg(a_reg), .cmp_sel(a_sel), .dispense(a_disp),
        .change_pulse(a_chg), .coin_reject(a_rej), .sel_err(a_err), .busy(a_busy)
    );

    // Instance B: PRICE4 raised to 15 for the saturation check
    logic       b_rst, b_sv, b_c1, b_c2, b_ge;
    logic [2:0] b_sel_in, b_sel;
    logic [3:0] b_reg;
    logic       b_disp, b_chg, b_rej, b_err, b_busy;

    assign b_ge = (b_reg >= price_of(b_sel, 4'd15));

    vending_sequencer #(.PRICE4(15)) dut_b (
        .clk(clk), .rst(b_rst), .sel_in(b_sel_in), .sel_valid(b_sv),
        .coin1(b_c1), .coin2(b_c2), .cancel(1'b0), .cmp_ge(b_ge),
        .cmp_reg(b_reg), .cmp_sel(b_sel), .dispense(b_disp),
        .change_pulse(b_chg), .coin_reject(b_rej), .sel_err(b_err), .busy(b_busy)
    );

    function automatic vec_t mk(input logic r, input logic sv, input logic [2:0] s,
                                input logic c1, input logic c2, input logic cn,
                                input logic [3:0] er, input logic [2:0] es, input logic [4:0] ef);
        vec_t v;
        v.rst = r; v.sv = sv; v.sel = s; v.c1 = c1; v.c2 = c2; v.cn = cn;
        v.exp_reg = er; v.exp_sel = es; v.exp_flags = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got reg=%0d sel=%0d flags=%b, want reg=%0d sel=%0d flags=%b",
                     name, act[11:8], act[7:5], act[4:0], exp[11:8], exp[7:5], exp[4:0]);
        end
    endtask

    function automatic logic [11:0] b_obs();
        return {b_reg, b_sel, b_disp, b_chg, b_rej, b_err, b_busy};
    endfunction

    task automatic b_step(input logic r, input logic sv, input logic [2:0] s,
                          input logic c1, input logic c2);
        b_rst = r; b_sv = sv; b_sel_in = s; b_c1 = c1; b_c2 = c2;
        @(posedge clk);
        #1;
    endtask

    vec_t vq[$];

    initial begin
        a_rst = 1'b1; a_sv = 1'b0; a_sel_in = 3'd0; a_c1 = 1'b0; a_c2 = 1'b0; a_cn = 1'b0;
        b_rst = 1'b1; b_sv = 1'b0; b_sel_in = 3'd0; b_c1 = 1'b0; b_c2 = 1'b0;

        // sel=2, coins 2,2: exact price, no change
        vq.push_back(mk(1,0,0,0,0,0, 0,0,5'b00000));
        vq.push_back(mk(0,1,2,0,0,0, 0,2,5'b00001));
        vq.push_back(mk(0,0,0,0,1,0, 2,2,5'b00001));
        vq.push_back(mk(0,0,0,0,1,0, 4,2,5'b00001));
        for (int i = 0; i < 4; i++) vq.push_back(mk(0,0,0,0,0,0, 0,2,5'b10001));
        vq.push_back(mk(0,0,0,0,0,0, 0,0,5'b00000));
        // sel=4 accepted in the first IDLE cycle, coins 2x4, one change unit, coin in DISPENSE
        vq.push_back(mk(0,1,4,0,0,0, 0,4,5'b00001));
        vq.push_back(mk(0,0,0,0,1,0, 2,4,5'b00001));
        vq.push_back(mk(0,0,0,0,1,0, 4,4,5'b00001));
        vq.push_back(mk(0,0,0,0,1,0, 6,4,5'b00001));
        vq.push_back(mk(0,0,0,0,1,0, 8,4,5'b00001));
        vq.push_back(mk(0,0,0,0,0,0, 1,4,5'b10001));
        vq.push_back(mk(0,0,0,1,0,0, 1,4,5'b10101));
        vq.push_back(mk(0,0,0,0,0,0, 1,4,5'b10001));
        vq.push_back(mk(0,0,0,0,0,0, 1,4,5'b10001));
        vq.push_back(mk(0,0,0,0,0,0, 1,4,5'b01001));
        vq.push_back(mk(0,0,0,0,0,0, 0,0,5'b00000));
        // sel=1 with both coins together: credit 3, two change pulses
        vq.push_back(mk(0,1,1,0,0,0, 0,1,5'b00001));
        vq.push_back(mk(0,0,0,1,1,0, 3,1,5'b00001));
        for (int i = 0; i < 4; i++) vq.push_back(mk(0,0,0,0,0,0, 2,1,5'b10001));
        vq.push_back(mk(0,0,0,0,0,0, 2,1,5'b01001));
        vq.push_back(mk(0,0,0,0,0,0, 1,1,5'b01001));
        vq.push_back(mk(0,0,0,0,0,0, 0,0,5'b00000));
        // idle errors: bad selections and a coin
        vq.push_back(mk(0,1,6,0,0,0, 0,0,5'b00010));
        vq.push_back(mk(0,0,0,1,0,0, 0,0,5'b00100));
        vq.push_back(mk(0,1,0,0,0,0, 0,0,5'b00010));
        // sel=3, coins 2,2, cancel, then a selection attempt and reset
        vq.push_back(mk(0,1,3,0,0,0, 0,3,5'b00001));
        vq.push_back(mk(0,0,0,0,1,0, 2,3,5'b00001));
        vq.push_back(mk(0,0,0,0,1,0, 4,3,5'b00001));
`ifdef VEND_CANCEL_EN
        vq.push_back(mk(0,0,0,0,0,1, 4,3,5'b01001));
        vq.push_back(mk(0,1,1,0,0,0, 3,3,5'b01011));
        vq.push_back(mk(0,0,0,0,0,0, 2,3,5'b01001));
`else
        vq.push_back(mk(0,0,0,0,0,1, 4,3,5'b00001));
        vq.push_back(mk(0,1,1,0,0,0, 4,3,5'b00011));
        vq.push_back(mk(0,0,0,0,0,0, 4,3,5'b00001));
`endif
        vq.push_back(mk(1,0,0,0,0,0, 0,0,5'b00000));
        vq.push_back(mk(0,0,0,0,0,0, 0,0,5'b00000));
        // coin in the cmp_ge cycle is still credited; reset during CHANGE
        vq.push_back(mk(0,1,1,0,0,0, 0,1,5'b00001));
        vq.push_back(mk(0,0,0,0,1,0, 2,1,5'b00001));
        for (int i = 0; i < 4; i++) vq.push_back(mk(0,0,0,0,(i == 0),0, 3,1,5'b10001));
        vq.push_back(mk(0,0,0,0,0,0, 3,1,5'b01001));
        vq.push_back(mk(1,0,0,0,0,0, 0,0,5'b00000));
        vq.push_back(mk(0,0,0,0,0,0, 0,0,5'b00000));

        foreach (vq[i]) begin
            a_rst = vq[i].rst; a_sv = vq[i].sv; a_sel_in = vq[i].sel;
            a_c1 = vq[i].c1; a_c2 = vq[i].c2; a_cn = vq[i].cn;
            @(posedge clk);
            #1;
            $display("vec %0d: rst=%0d sv=%0d sel_in=%0d c1=%0d c2=%0d cn=%0d -> reg=%0d sel=%0d flags=%b",
                     i, vq[i].rst, vq[i].sv, vq[i].sel, vq[i].c1, vq[i].c2, vq[i].cn,
                     a_reg, a_sel, {a_disp, a_chg, a_rej, a_err, a_busy});
            check($sformatf("vec%0d", i), {a_reg, a_sel, a_disp, a_chg, a_rej, a_err, a_busy},
                  {vq[i].exp_reg, vq[i].exp_sel, vq[i].exp_flags});
        end

        // Saturation on PRICE4=15
        b_step(1, 0, 0, 0, 0);
        check("sat_reset", b_obs(), {4'd0, 3'd0, 5'b00000});
        b_step(0, 1, 4, 0, 0);
        check("sat_sel", b_obs(), {4'd0, 3'd4, 5'b00001});
        for (int k = 1; k <= 7; k++) begin
            b_step(0, 0, 0, 0, 1);
            $display("sat coin2 #%0d -> reg=%0d", k, b_reg);
        end
        check("sat_14", b_obs(), {4'd14, 3'd4, 5'b00001});
        b_step(0, 0, 0, 1, 1);
        check("sat_both_rej", b_obs(), {4'd14, 3'd4, 5'b00101});
        b_step(0, 0, 0, 0, 1);
        check("sat_coin2_rej", b_obs(), {4'd14, 3'd4, 5'b00101});
        b_step(0, 0, 0, 1, 0);
        check("sat_15", b_obs(), {4'd15, 3'd4, 5'b00001});
        b_step(0, 0, 0, 0, 0);
        check("sat_disp", b_obs(), {4'd0, 3'd4, 5'b10001});
        for (int k = 0; k < 3; k++) b_step(0, 0, 0, 0, 0);
        check("sat_disp_last", b_obs(), {4'd0, 3'd4, 5'b10001});
        b_step(0, 0, 0, 0, 0);
        check("sat_idle", b_obs(), {4'd0, 3'd0, 5'b00000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
